// File: rtl/exp_sum_accum_pkg.sv
// Shared softmax definitions: FSM state encoding and Q16.16 format constants.
package exp_sum_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int          FRAC_BITS = 16;
    localparam logic [31:0] ONE_Q     = 32'h0001_0000;
    localparam logic [31:0] SAT_MAX   = 32'hFFFF_FFFF;

endpackage

// File: rtl/exp_sum_accum_sat_add.sv
// Combinational unsigned saturating adder; clamps to all-ones and flags overflow.
module sat_add_u #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum,
    output logic          ovf
);

    logic [DW:0] wide;

    assign wide = {1'b0, a} + {1'b0, b};
    assign ovf  = wide[DW];
    assign sum  = wide[DW] ? {DW{1'b1}} : wide[DW-1:0];

endmodule

// File: rtl/exp_sum_accum.sv
// Streaming saturating accumulator of softmax exponent terms feeding the log unit.
//   state | meaning
//   IDLE  | no partial sum held, ready for the first term of a vector
//   ACCUM | partial sum held in acc/cnt/ovf, adding terms until in_last
//   HOLD  | out_* presented with out_valid; a new vector may start on handshake
module exp_sum_accum
    import exp_sum_accum_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [DW-1:0]    out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t           state;
    logic [DW-1:0]    acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             accept;
    logic             hs;
    logic [DW-1:0]    add_sum;
    logic             add_ovf;
    logic             acc_ovf;
    logic [CNT_W-1:0] cnt_inc;

    // Holding a result blocks new terms only while the log unit stalls.
    assign in_ready = (state == HOLD) ? out_ready : 1'b1;
    assign accept   = in_valid && in_ready;
    assign hs       = out_valid && out_ready;

    sat_add_u #(.DW(DW)) u_add (
        .a   (acc),
        .b   (in_data),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    assign acc_ovf = ovf | add_ovf;
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (hs) begin
                out_valid <= 1'b0;
            end
            case (state)
                // In HOLD an accept implies the handshake, so both states start a vector alike.
                IDLE, HOLD: begin
                    if (accept) begin
                        if (in_last) begin
                            out_sum   <= in_data;
                            out_count <= CNT_W'(1);
                            out_ovf   <= 1'b0;
                            out_zero  <= (in_data == '0);
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            acc   <= in_data;
                            cnt   <= CNT_W'(1);
                            ovf   <= 1'b0;
                            state <= ACCUM;
                        end
                    end else if (hs) begin
                        state <= IDLE;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= add_sum;
                        cnt <= cnt_inc;
                        ovf <= acc_ovf;
                        if (in_last) begin
                            out_sum   <= add_sum;
                            out_count <= cnt_inc;
                            out_ovf   <= acc_ovf;
                            out_zero  <= (add_sum == '0);
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_sum_accum.sv
// Directed bench for exp_sum_accum: vector-level model plus literal pins on each result.
module tb_exp_sum_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_sum;
    logic [15:0] out_count;
    logic        out_ovf;
    logic        out_zero;
    logic        out_valid;
    logic        out_ready;

    exp_sum_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic [15:0] cnt;
        logic        ovf;
        logic        zero;
    } result_t;

    result_t         exp_q[$];
    longint unsigned total;
    int              n_terms;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] last_sum;
    logic [15:0] last_cnt;
    logic        last_ovf;
    logic        last_zero;
    int          n_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Result of a vector from its terms: true sum clamped to 32 bits, overflow iff it did not fit.
    task automatic model_accept(input logic [31:0] d, input logic last);
        result_t r;
        total += d;
        n_terms++;
        if (last) begin
            r.sum  = (total > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : total[31:0];
            r.cnt  = (n_terms > 65535) ? 16'hFFFF : n_terms[15:0];
            r.ovf  = (total > 64'hFFFF_FFFF);
            r.zero = (total == 0);
            exp_q.push_back(r);
            total   = 0;
            n_terms = 0;
        end
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        bit accepted = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int i = 0; i < 100 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1;
                model_accept(d, last);
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) chk("send_timeout", 64'(accepted), 64'd1);
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #3;
        end
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    // Per-cycle compare, sampled 2 time units after the rising edge.
    always begin
        @(posedge clk);
        #2;
        if (rst_n) begin
            chk("in_ready", 64'(in_ready), 64'(out_valid ? out_ready : 1'b1));
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 64'(out_valid), 64'd0);
            end else begin
                chk("missing_valid", 64'(out_valid), 64'd1);
                if (out_valid) begin
                    chk("out_sum", 64'(out_sum), 64'(exp_q[0].sum));
                    chk("out_count", 64'(out_count), 64'(exp_q[0].cnt));
                    chk("out_ovf", 64'(out_ovf), 64'(exp_q[0].ovf));
                    chk("out_zero", 64'(out_zero), 64'(exp_q[0].zero));
                    if (out_ready) begin
                        last_sum  = out_sum;
                        last_cnt  = out_count;
                        last_ovf  = out_ovf;
                        last_zero = out_zero;
                        n_done++;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int done0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        total     = 0;
        n_terms   = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sum", 64'(out_sum), 64'd0);
        chk("rst_count", 64'(out_count), 64'd0);
        chk("rst_ovf", 64'(out_ovf), 64'd0);
        chk("rst_zero", 64'(out_zero), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Four terms of 1.0
        done0 = n_done;
        for (int i = 0; i < 4; i++) send(32'h0001_0000, i == 3);
        wait_drain();
        chk("t1_sum", 64'(last_sum), 64'h0004_0000);
        chk("t1_count", 64'(last_cnt), 64'd4);
        chk("t1_ovf", 64'(last_ovf), 64'd0);
        chk("t1_zero", 64'(last_zero), 64'd0);
        chk("t1_pulses", 64'(n_done - done0), 64'd1);

        // Single-term vector from IDLE
        send(32'h0000_8000, 1'b1);
        wait_drain();
        chk("t2_sum", 64'(last_sum), 64'h0000_8000);
        chk("t2_count", 64'(last_cnt), 64'd1);

        // Saturation, then the ovf flag clears on the following vector
        send(32'hFFFF_0000, 1'b0);
        send(32'h0002_0000, 1'b1);
        wait_drain();
        chk("t3_sum", 64'(last_sum), 64'hFFFF_FFFF);
        chk("t3_ovf", 64'(last_ovf), 64'd1);
        chk("t3_count", 64'(last_cnt), 64'd2);
        send(32'hFFFF_0000, 1'b0);
        send(32'h0002_0000, 1'b1);
        send(32'h0001_0000, 1'b1);
        wait_drain();
        chk("t3b_sum", 64'(last_sum), 64'h0001_0000);
        chk("t3b_ovf", 64'(last_ovf), 64'd0);

        // All-zero vector
        for (int i = 0; i < 3; i++) send(32'h0, i == 2);
        wait_drain();
        chk("t4_sum", 64'(last_sum), 64'd0);
        chk("t4_zero", 64'(last_zero), 64'd1);
        chk("t4_count", 64'(last_cnt), 64'd3);

        // Log unit stalls in HOLD while the next vector is offered
        out_ready = 1'b0;
        send(32'h0003_0000, 1'b0);
        send(32'h0000_4000, 1'b1);
        fork
            begin
                send(32'h0002_0000, 1'b0);
                send(32'h0005_0000, 1'b1);
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("t5_stall_ready", 64'(in_ready), 64'd0);
                    chk("t5_stall_sum", 64'(out_sum), 64'h0003_4000);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("t5_sum", 64'(last_sum), 64'h0007_0000);
        chk("t5_count", 64'(last_cnt), 64'd2);

        // Reset in the middle of a vector
        send(32'h0001_0000, 1'b0);
        send(32'h0001_0000, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_sum", 64'(out_sum), 64'd0);
        chk("t6_rst_count", 64'(out_count), 64'd0);
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        total   = 0;
        n_terms = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        done0 = n_done;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_valid", 64'(n_done - done0), 64'd0);
        send(32'h0001_0000, 1'b0);
        send(32'h0001_0000, 1'b1);
        wait_drain();
        chk("t6_sum", 64'(last_sum), 64'h0002_0000);
        chk("t6_count", 64'(last_cnt), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule
